fm_3d_mwb_bridge: RTL and testbench

//  Downstream neighbour of fm_3d_core's native master port (o_req_m/o_len_m/i_strr_m); converts its burst

---
 rtl/fm_3d_mwb_bridge_pkg.sv | 14 +
 rtl/fm_3d_mwb_timeout.sv | 37 +++
 rtl/fm_3d_mwb_bridge.sv | 186 ++++++++++++++++++
 tb/tb_fm_3d_mwb_bridge.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fm_3d_mwb_bridge_pkg.sv
// Shared definitions for the fm_3d master-port to WishBone bridge.
package fm_3d_mwb_bridge_pkg;

    localparam int P_LEN_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_WR_WAIT,
        ST_DRAIN
    } mwb_state_e;

endpackage

// File: rtl/fm_3d_mwb_timeout.sv
// Watchdog: counts enabled cycles and pulses expire on the P_TO'th one; P_TO=0 never expires.
module fm_3d_mwb_timeout #(
    parameter int P_TO_W = 8,
    parameter int P_TO   = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [P_TO_W-1:0] TERM = (P_TO == 0) ? P_TO_W'(0) : P_TO_W'(P_TO - 1);

    logic [P_TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        expire = 1'b0;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (P_TO != 0 && cnt_q == TERM) begin
                expire = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fm_3d_mwb_bridge.sv
// Converts fm_3d_core master bursts into WishBone classic single-beat cycles,
// holding CYC per burst and aborting hung cycles through a watchdog.
module fm_3d_mwb_bridge
    import fm_3d_mwb_bridge_pkg::*;
#(
    parameter int P_TO_W = 8,
    parameter int P_TO   = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_req,
    input  logic               i_wr,
    input  logic [31:0]        i_adrs,
    input  logic [P_LEN_W-1:0] i_len,
    output logic               o_ack,
    input  logic [3:0]         i_be,
    input  logic [31:0]        i_dbw,
    output logic               o_strr,
    output logic [31:0]        o_dbr,
    output logic               o_err,
    input  logic               i_err_clr,
    output logic               m_wb_cyc_o,
    output logic               m_wb_stb_o,
    output logic               m_wb_we_o,
    output logic [29:0]        m_wb_adr_o,
    output logic [3:0]         m_wb_sel_o,
    output logic [31:0]        m_wb_dat_o,
    input  logic               m_wb_ack_i,
    input  logic [31:0]        m_wb_dat_i
);

    mwb_state_e         state_q, state_d;
    logic [P_LEN_W-1:0] rem_q, rem_d;
    logic [29:0]        adr_q, adr_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        dat_q, dat_d, dbr_q, dbr_d;
    logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic               ack_q, ack_d, strr_q, strr_d, err_q, err_d;
    logic               wd_en, wd_clr, wd_expire, take;
    logic               unused_adr;

    assign unused_adr = ^i_adrs[1:0];

    // The core keeps i_req up through the cycle o_ack is visible; skip that stale request.
    assign take   = i_req & ~ack_q;
    assign wd_en  = stb_q & ~m_wb_ack_i;
    assign wd_clr = m_wb_ack_i | ~(state_q == ST_RD || state_q == ST_WR);

    fm_3d_mwb_timeout #(.P_TO_W(P_TO_W), .P_TO(P_TO)) u_timeout (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en     (wd_en),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        dbr_d   = dbr_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        strr_d  = 1'b0;
        err_d   = i_err_clr ? 1'b0 : err_q;
        case (state_q)
            ST_IDLE: if (take) begin
                ack_d = 1'b1;
                adr_d = i_adrs[31:2];
                rem_d = i_len;
                cyc_d = 1'b1;
                stb_d = 1'b1;
                we_d  = i_wr;
                if (i_wr) begin
                    sel_d   = i_be;
                    dat_d   = i_dbw;
                    state_d = ST_WR;
                end else begin
                    sel_d   = 4'hf;
                    state_d = ST_RD;
                end
            end
            ST_RD: if (m_wb_ack_i) begin
                strr_d = 1'b1;
                dbr_d  = m_wb_dat_i;
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                end else begin
                    adr_d = adr_q + 30'd1;
                    rem_d = rem_q - 1'b1;
                end
            end else if (wd_expire) begin
                state_d = ST_DRAIN;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                err_d   = 1'b1;
            end
            ST_WR: if (m_wb_ack_i) begin
                stb_d = 1'b0;
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                end else begin
                    state_d = ST_WR_WAIT;
                    adr_d   = adr_q + 30'd1;
                    rem_d   = rem_q - 1'b1;
                end
            end else if (wd_expire) begin
                state_d = ST_DRAIN;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                err_d   = 1'b1;
            end
            ST_WR_WAIT: if (take && i_wr) begin
                ack_d   = 1'b1;
                sel_d   = i_be;
                dat_d   = i_dbw;
                stb_d   = 1'b1;
                state_d = ST_WR;
            end
            ST_DRAIN: if (we_q) begin
                // Swallow the beats the core still owes so it can finish its burst.
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else if (take && i_wr) begin
                    ack_d = 1'b1;
                    rem_d = rem_q - 1'b1;
                end
            end else begin
                strr_d = 1'b1;
                dbr_d  = '0;
                if (rem_q == '0) state_d = ST_IDLE;
                else             rem_d   = rem_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            dbr_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            strr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            dbr_q   <= dbr_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            strr_q  <= strr_d;
            err_q   <= err_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_strr     = strr_q;
    assign o_dbr      = dbr_q;
    assign o_err      = err_q;
    assign m_wb_cyc_o = cyc_q;
    assign m_wb_stb_o = stb_q;
    assign m_wb_we_o  = we_q;
    assign m_wb_adr_o = adr_q;
    assign m_wb_sel_o = sel_q;
    assign m_wb_dat_o = dat_q;

endmodule

// File: tb/tb_fm_3d_mwb_bridge.sv
// Randomized bench: core driver and WB slave models, checked against burst-level expectations.
module tb_fm_3d_mwb_bridge;

    localparam int P_TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        i_req, i_wr, i_err_clr;
    logic [31:0] i_adrs, i_dbw;
    logic [2:0]  i_len;
    logic [3:0]  i_be;
    logic        o_ack, o_strr, o_err;
    logic [31:0] o_dbr;
    logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_ack_i;
    logic [29:0] m_wb_adr_o;
    logic [3:0]  m_wb_sel_o;
    logic [31:0] m_wb_dat_o, m_wb_dat_i;

    fm_3d_mwb_bridge #(.P_TO_W(8), .P_TO(P_TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req(i_req), .i_wr(i_wr), .i_adrs(i_adrs), .i_len(i_len), .o_ack(o_ack),
        .i_be(i_be), .i_dbw(i_dbw), .o_strr(o_strr), .o_dbr(o_dbr),
        .o_err(o_err), .i_err_clr(i_err_clr),
        .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_dat_o(m_wb_dat_o),
        .m_wb_ack_i(m_wb_ack_i), .m_wb_dat_i(m_wb_dat_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [29:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } wb_t;

    int          checks = 0, failures = 0;
    wb_t         got_wb[$];
    logic [31:0] got_rd[$];
    logic [3:0]  be_q[8];
    logic [31:0] dw_q[8];
    int          wait_max = 0, wait_left = -1, wbeat = 0, nbeats = 0;
    int          n_ack = 0, n_cyc = 0, cyc_fell = 0;
    bit          hang = 0, clr_on_hang = 0, saw_wait = 0, prev_cyc = 0, exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata(input logic [29:0] a);
        return {a, 2'b01} ^ 32'hC3A5_5A3C;
    endfunction

    // One clock: sample outputs 1ns after the edge, then update core and slave inputs.
    task automatic step();
        @(posedge clk_i);
        #1;
        if (o_strr) got_rd.push_back(o_dbr);
        if (o_ack) n_ack++;
        if (m_wb_cyc_o) n_cyc++;
        if (m_wb_cyc_o && !m_wb_stb_o) saw_wait = 1;
        if (prev_cyc && !m_wb_cyc_o) cyc_fell++;
        prev_cyc = m_wb_cyc_o;
        if (o_ack && i_req) begin
            if (!i_wr) i_req = 1'b0;
            else begin
                wbeat++;
                if (wbeat < nbeats) begin
                    i_be  = be_q[wbeat];
                    i_dbw = dw_q[wbeat];
                end else i_req = 1'b0;
            end
        end
        m_wb_ack_i = 1'b0;
        m_wb_dat_i = $urandom;
        if (m_wb_cyc_o && m_wb_stb_o && !hang) begin
            if (wait_left < 0) wait_left = $urandom_range(wait_max, 0);
            if (wait_left == 0) begin
                m_wb_ack_i = 1'b1;
                if (!m_wb_we_o) m_wb_dat_i = rdata(m_wb_adr_o);
                got_wb.push_back('{m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_dat_o});
                wait_left = -1;
            end else wait_left--;
        end else wait_left = -1;
        if (clr_on_hang) i_err_clr = (m_wb_cyc_o && n_cyc == P_TO);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 8; k++) begin
            be_q[k] = 4'($urandom);
            dw_q[k] = $urandom;
        end
    endtask

    task automatic run_burst(input bit wr, input logic [31:0] adrs, input logic [2:0] len,
                             input string tag);
        int beats = int'(len) + 1;
        bit done = 0;
        got_wb.delete(); got_rd.delete();
        n_ack = 0; n_cyc = 0; cyc_fell = 0; saw_wait = 0; prev_cyc = m_wb_cyc_o;
        nbeats = beats; wbeat = 0;
        i_req = 1'b1; i_wr = wr; i_adrs = adrs; i_len = len; i_be = be_q[0]; i_dbw = dw_q[0];
        for (int c = 0; c < 300 && !done; c++) begin
            step();
            done = wr ? (got_wb.size() == beats) : (got_rd.size() == beats);
        end
        if (wr) step();
        if (hang) exp_err = 1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_nack"}, n_ack, wr ? beats : 1);
        chk({tag, "_cycfall"}, cyc_fell, 1);
        chk({tag, "_cyc_end"}, 32'(m_wb_cyc_o), 0);
        chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
        chk({tag, "_wait"}, 32'(saw_wait), 32'(wr && beats > 1));
        if (hang) begin
            chk({tag, "_ncyc"}, n_cyc, P_TO);
            chk({tag, "_nwb"}, got_wb.size(), 0);
        end else begin
            chk({tag, "_nwb"}, got_wb.size(), beats);
            for (int k = 0; k < beats && k < got_wb.size(); k++) begin
                logic [29:0] ea = adrs[31:2] + 30'(k);
                chk({tag, "_adr"}, 32'(got_wb[k].adr), 32'(ea));
                chk({tag, "_we"}, 32'(got_wb[k].we), 32'(wr));
                chk({tag, "_sel"}, 32'(got_wb[k].sel), wr ? 32'(be_q[k]) : 32'hf);
                if (wr) chk({tag, "_wdat"}, got_wb[k].dat, dw_q[k]);
            end
        end
        if (!wr) begin
            chk({tag, "_nrd"}, got_rd.size(), beats);
            for (int k = 0; k < beats && k < got_rd.size(); k++) begin
                logic [29:0] ea = adrs[31:2] + 30'(k);
                chk({tag, "_rdat"}, got_rd[k], hang ? 32'h0 : rdata(ea));
            end
        end
    endtask

    initial begin
        rst_i = 1'b1; i_req = 1'b0; i_wr = 1'b0; i_adrs = '0; i_len = '0;
        i_be = '0; i_dbw = '0; i_err_clr = 1'b0; m_wb_ack_i = 1'b0; m_wb_dat_i = '0;
        repeat (3) step();
        chk("rst_cyc", 32'(m_wb_cyc_o), 0);
        chk("rst_stb", 32'(m_wb_stb_o), 0);
        chk("rst_ack", 32'(o_ack), 0);
        chk("rst_strr", 32'(o_strr), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_dbr", o_dbr, 0);
        chk("rst_adr", 32'(m_wb_adr_o), 0);
        rst_i = 1'b0;
        step();

        wait_max = 0; fill_rand();
        run_burst(1'b0, 32'h100, 3'd3, "t1_rd");

        fill_rand(); be_q[0] = 4'h3; be_q[1] = 4'hc;
        run_burst(1'b1, 32'hFFFF_FFFC, 3'd1, "t2_wr");

        hang = 1; fill_rand();
        run_burst(1'b0, 32'h400, 3'd2, "t3_hang");
        hang = 0;

        i_err_clr = 1'b1; step(); i_err_clr = 1'b0; exp_err = 0;
        chk("t6_clr_alone", 32'(o_err), 0);
        hang = 1; clr_on_hang = 1;
        run_burst(1'b0, 32'h2000, 3'd0, "t6_clr_race");
        hang = 0; clr_on_hang = 0; i_err_clr = 1'b0;
        i_err_clr = 1'b1; step(); i_err_clr = 1'b0; exp_err = 0;
        chk("t6_clr_later", 32'(o_err), 0);

        wait_max = 5;
        run_burst(1'b0, 32'h8000, 3'd7, "t4_rd_wait");

        wait_max = 0; got_rd.delete();
        i_req = 1'b1; i_wr = 1'b0; i_adrs = 32'h300; i_len = 3'd3; nbeats = 4; wbeat = 0;
        for (int c = 0; c < 50 && got_rd.size() < 1; c++) step();
        chk("t5_pre", got_rd.size(), 1);
        rst_i = 1'b1; i_req = 1'b0;
        step();
        chk("t5_cyc", 32'(m_wb_cyc_o), 0);
        chk("t5_stb", 32'(m_wb_stb_o), 0);
        chk("t5_strr", 32'(o_strr), 0);
        chk("t5_ack", 32'(o_ack), 0);
        rst_i = 1'b0; exp_err = 0;
        step();
        run_burst(1'b0, 32'h500, 3'd1, "t5_after");

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a = (i % 5 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            wait_max = $urandom_range(3, 0);
            fill_rand();
            run_burst(1'($urandom_range(1, 0)), a, 3'($urandom_range(7, 0)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
